reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DEPTH, default 4, entries per bank (add bank and multiply bank each).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 dispatch_valid  input  1  dispatch request this cycle.
REQ-005 rs_select  input  2  target bank: 0 = add, 1 = multiply, 2/3 = ignored.
REQ-006 dispatch_ps_ready1 / dispatch_ps_ready2  input  1 each  source operand already available.
REQ-007 ps1 / ps2  input  32 each  physical source tags.
REQ-008 rd  input  32  architectural destination.
REQ-009 pd  input  32  physical destination tag.
REQ-010 rob_entry  input  32  ROB index.
REQ-011 cdb_ps_id  input  32  broadcast completing tag; 32'hFFFF_FFFF = no broadcast.
REQ-012 add_fu_busy / multiply_fu_busy  input  1 each  FU cannot accept issue.
REQ-013 add_regf_we  output  1  add-bank issue valid.
REQ-014 multiply_fu_ready  output  1  multiply-bank issue valid.
REQ-015 add_cdb / multiply_cdb  output  160 each  issue packet {rob_entry[159:128], pd[127:96], rd[95:64], ps2[63:32], ps1[31:0]}.

Function
REQ-016 Entry state SHALL be: valid, ps1, ps1_rdy, ps2, ps2_rdy, rd, pd, rob_entry.
REQ-017 On dispatch_valid with rs_select 0/1, the lowest-index entry invalid at cycle start in the selected bank SHALL be written at the edge; bank full -> request dropped silently.
REQ-018 On dispatch_valid with rs_select 2 or 3, no state SHALL change.
REQ-019 When cdb_ps_id is not all-ones, every valid entry whose ps1 (ps2) equals it SHALL set ps1_rdy (ps2_rdy) at the edge, in both banks.
REQ-020 Issue selection SHALL be combinational: per bank, lowest-index valid entry with both ready bits set, only if the bank's FU busy input is 0.
REQ-021 A selected entry SHALL drive its packet and assert the bank's valid output in the same cycle, and SHALL be invalidated at that edge.
REQ-022 With no selection, the bank's packet SHALL be all zeros and its valid output 0.
REQ-023 A dispatched entry with both operands ready SHALL issue in the first cycle after its dispatch edge, absent FU busy or lower-index ready entries.
REQ-024 A slot freed by issue SHALL NOT accept a dispatch in the same cycle.
REQ-025 Add and multiply banks SHALL operate independently; both may issue in one cycle.

Reset
REQ-026 rst=1 at an edge SHALL clear all valid and ready bits in both banks, overriding simultaneous dispatch/wakeup.
REQ-027 During and after reset, add_regf_we=0, multiply_fu_ready=0, add_cdb=0, multiply_cdb=0 until a ready entry exists.

Configuration
REQ-028 Macro RS_CDB_BYPASS_EN: defined -> a dispatched operand whose tag equals a non-sentinel cdb_ps_id in the dispatch cycle SHALL be stored ready; undefined -> stored ready bits equal dispatch_ps_ready1/2 exactly (that wakeup is lost).

Structure
REQ-029 Package rs_pkg SHALL hold: entry struct, 160-bit issue-packet struct, RS_SEL_ADD=0 / RS_SEL_MUL=1 constants, CDB_NONE=all-ones constant.
REQ-030 Sub-module rs_bank (one bank: storage, wakeup, select) SHALL be instantiated twice in the top.

Verification
REQ-031 Reset, then dispatch add {ps1=32 rdy, ps2=33 not rdy, rd=2, pd=45, rob=0}, cdb=38 -> no issue; later cdb_ps_id=33 -> next cycle add_regf_we=1, add_cdb={0,45,2,33,32}.
REQ-032 Dispatch add {34 rdy, 35 rdy, rd=4, pd=65, rob=1} -> next cycle add_regf_we=1 for one cycle, add_cdb={1,65,4,35,34}; following cycle 0.
REQ-033 Repeat REQ-032 with add_fu_busy=1 held -> no issue; deassert -> issues that cycle.
REQ-034 Six add dispatches, all with ps2 not ready (tags 33,37,39,35,37, plus one), no wakeups -> first four stored, last two dropped; add_regf_we stays 0.
REQ-035 Ready dispatch with rs_select=1 -> multiply_fu_ready=1 with packet, add outputs 0; rs_select=2 -> nothing stored.
REQ-036 Assert rst with valid ready entries -> next cycle all outputs 0, entries gone.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation station: the entry record, the
// 160-bit issue packet, the bank-select codes and the "no broadcast" CDB tag.
package rs_pkg;

    localparam int TAG_W = 32;
    localparam int PKT_W = 160;

    localparam logic [1:0]       RS_SEL_ADD = 2'd0;
    localparam logic [1:0]       RS_SEL_MUL = 2'd1;
    localparam logic [TAG_W-1:0] CDB_NONE   = 32'hFFFF_FFFF;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] ps1;
        logic             ps1_rdy;
        logic [TAG_W-1:0] ps2;
        logic             ps2_rdy;
        logic [TAG_W-1:0] rd;
        logic [TAG_W-1:0] pd;
        logic [TAG_W-1:0] rob_entry;
    } rs_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] rob_entry;
        logic [TAG_W-1:0] pd;
        logic [TAG_W-1:0] rd;
        logic [TAG_W-1:0] ps2;
        logic [TAG_W-1:0] ps1;
    } rs_pkt_t;

    // A real broadcast never carries the sentinel tag.
    function automatic logic tag_hit(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] cdb);
        return (cdb != CDB_NONE) && (tag == cdb);
    endfunction

    function automatic rs_pkt_t entry_pkt(input rs_entry_t e);
        return '{rob_entry: e.rob_entry, pd: e.pd, rd: e.rd, ps2: e.ps2, ps1: e.ps1};
    endfunction

endpackage

// File: rtl/rs_bank.sv
// One reservation-station bank: DEPTH entries with dispatch, CDB wakeup and
// lowest-index issue select. Optional macro RS_CDB_BYPASS_EN captures a same-cycle broadcast at dispatch.
import rs_pkg::*;

module rs_bank #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_en,
    input  logic             dispatch_ps_ready1,
    input  logic             dispatch_ps_ready2,
    input  logic [TAG_W-1:0] ps1,
    input  logic [TAG_W-1:0] ps2,
    input  logic [TAG_W-1:0] rd,
    input  logic [TAG_W-1:0] pd,
    input  logic [TAG_W-1:0] rob_entry,
    input  logic [TAG_W-1:0] cdb_ps_id,
    input  logic             fu_busy,
    output logic             issue_valid,
    output rs_pkt_t          issue_pkt
);

    rs_entry_t        entries_r [DEPTH];
    logic [DEPTH-1:0] free_oh_s;
    logic [DEPTH-1:0] sel_oh_s;
    logic             free_found_s;
    logic             sel_found_s;
    logic             issue_s;
    logic             ps1_rdy_in_s;
    logic             ps2_rdy_in_s;
    logic [PKT_W-1:0] pkt_s;

`ifdef RS_CDB_BYPASS_EN
    assign ps1_rdy_in_s = dispatch_ps_ready1 | tag_hit(ps1, cdb_ps_id);
    assign ps2_rdy_in_s = dispatch_ps_ready2 | tag_hit(ps2, cdb_ps_id);
`else
    assign ps1_rdy_in_s = dispatch_ps_ready1;
    assign ps2_rdy_in_s = dispatch_ps_ready2;
`endif

    // Priority-encode the lowest free slot and the lowest fully-ready entry.
    always_comb begin
        free_oh_s    = '0;
        sel_oh_s     = '0;
        free_found_s = 1'b0;
        sel_found_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found_s && !entries_r[i].valid) begin
                free_oh_s[i] = 1'b1;
                free_found_s = 1'b1;
            end else begin
                free_oh_s[i] = 1'b0;
            end
            if (!sel_found_s && entries_r[i].valid && entries_r[i].ps1_rdy && entries_r[i].ps2_rdy) begin
                sel_oh_s[i] = 1'b1;
                sel_found_s = 1'b1;
            end else begin
                sel_oh_s[i] = 1'b0;
            end
        end
    end

    // One-hot AND-OR mux of the selected entry into the packet.
    always_comb begin
        pkt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pkt_s = pkt_s | ({PKT_W{sel_oh_s[i]}} & entry_pkt(entries_r[i]));
        end
    end

    assign issue_s     = sel_found_s & ~fu_busy;
    assign issue_valid = issue_s;
    assign issue_pkt   = issue_s ? rs_pkt_t'(pkt_s) : '0;

    // Entry storage: reset, dispatch into the free slot, issue invalidate, wakeup.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i].valid   <= 1'b0;
                entries_r[i].ps1_rdy <= 1'b0;
                entries_r[i].ps2_rdy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dispatch_en && free_oh_s[i]) begin
                    entries_r[i] <= '{valid: 1'b1, ps1: ps1, ps1_rdy: ps1_rdy_in_s,
                                      ps2: ps2, ps2_rdy: ps2_rdy_in_s,
                                      rd: rd, pd: pd, rob_entry: rob_entry};
                end else begin
                    if (issue_s && sel_oh_s[i]) begin
                        entries_r[i].valid <= 1'b0;
                    end
                    if (entries_r[i].valid && tag_hit(entries_r[i].ps1, cdb_ps_id)) begin
                        entries_r[i].ps1_rdy <= 1'b1;
                    end
                    if (entries_r[i].valid && tag_hit(entries_r[i].ps2, cdb_ps_id)) begin
                        entries_r[i].ps2_rdy <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station top: independent add and multiply banks sharing one
// dispatch port and one CDB. Optional macro RS_CDB_BYPASS_EN (see rs_bank).
import rs_pkg::*;

module reservation_station #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_valid,
    input  logic [1:0]       rs_select,
    input  logic             dispatch_ps_ready1,
    input  logic             dispatch_ps_ready2,
    input  logic [TAG_W-1:0] ps1,
    input  logic [TAG_W-1:0] ps2,
    input  logic [TAG_W-1:0] rd,
    input  logic [TAG_W-1:0] pd,
    input  logic [TAG_W-1:0] rob_entry,
    input  logic [TAG_W-1:0] cdb_ps_id,
    input  logic             add_fu_busy,
    input  logic             multiply_fu_busy,
    output logic             add_regf_we,
    output logic             multiply_fu_ready,
    output logic [PKT_W-1:0] add_cdb,
    output logic [PKT_W-1:0] multiply_cdb
);

    logic    add_en_s;
    logic    mul_en_s;
    rs_pkt_t add_pkt_s;
    rs_pkt_t mul_pkt_s;

    // Select codes 2 and 3 enable neither bank.
    assign add_en_s = dispatch_valid && (rs_select == RS_SEL_ADD);
    assign mul_en_s = dispatch_valid && (rs_select == RS_SEL_MUL);

    rs_bank #(.DEPTH(DEPTH)) u_add_bank (
        .clk                (clk),
        .rst                (rst),
        .dispatch_en        (add_en_s),
        .dispatch_ps_ready1 (dispatch_ps_ready1),
        .dispatch_ps_ready2 (dispatch_ps_ready2),
        .ps1                (ps1),
        .ps2                (ps2),
        .rd                 (rd),
        .pd                 (pd),
        .rob_entry          (rob_entry),
        .cdb_ps_id          (cdb_ps_id),
        .fu_busy            (add_fu_busy),
        .issue_valid        (add_regf_we),
        .issue_pkt          (add_pkt_s)
    );

    rs_bank #(.DEPTH(DEPTH)) u_mul_bank (
        .clk                (clk),
        .rst                (rst),
        .dispatch_en        (mul_en_s),
        .dispatch_ps_ready1 (dispatch_ps_ready1),
        .dispatch_ps_ready2 (dispatch_ps_ready2),
        .ps1                (ps1),
        .ps2                (ps2),
        .rd                 (rd),
        .pd                 (pd),
        .rob_entry          (rob_entry),
        .cdb_ps_id          (cdb_ps_id),
        .fu_busy            (multiply_fu_busy),
        .issue_valid        (multiply_fu_ready),
        .issue_pkt          (mul_pkt_s)
    );

    assign add_cdb      = add_pkt_s;
    assign multiply_cdb = mul_pkt_s;

endmodule

// File: tb/tb_reservation_station.sv
// Randomized and directed bench for reservation_station against a slot-list
// reference model; compile with RS_CDB_BYPASS_EN to check the bypass build.
module tb_reservation_station;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst, dispatch_valid, dispatch_ps_ready1, dispatch_ps_ready2;
    logic [1:0]   rs_select;
    logic [31:0]  ps1, ps2, rd, pd, rob_entry, cdb_ps_id;
    logic         add_fu_busy, multiply_fu_busy;
    logic         add_regf_we, multiply_fu_ready;
    logic [159:0] add_cdb, multiply_cdb;

    reservation_station #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .dispatch_valid(dispatch_valid), .rs_select(rs_select),
        .dispatch_ps_ready1(dispatch_ps_ready1), .dispatch_ps_ready2(dispatch_ps_ready2),
        .ps1(ps1), .ps2(ps2), .rd(rd), .pd(pd), .rob_entry(rob_entry), .cdb_ps_id(cdb_ps_id),
        .add_fu_busy(add_fu_busy), .multiply_fu_busy(multiply_fu_busy),
        .add_regf_we(add_regf_we), .multiply_fu_ready(multiply_fu_ready),
        .add_cdb(add_cdb), .multiply_cdb(multiply_cdb)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v, r1, r2;
        logic [31:0] ps1, ps2, rd, pd, rob;
    } ment_t;

    ment_t mdl [2][DEPTH];
    int    total = 0;
    int    bad   = 0;

    bit          s_rst, s_dv, s_r1, s_r2, s_abusy, s_mbusy;
    logic [1:0]  s_sel;
    logic [31:0] s_ps1, s_ps2, s_rd, s_pd, s_rob, s_cdb;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        s_rst = 1'b0; s_dv = 1'b0; s_sel = 2'd0; s_r1 = 1'b0; s_r2 = 1'b0;
        s_ps1 = 32'd0; s_ps2 = 32'd0; s_rd = 32'd0; s_pd = 32'd0; s_rob = 32'd0;
        s_cdb = NONE;
    endtask

    task automatic disp(input logic [1:0] sel, input bit r1, input bit r2, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] d, input logic [31:0] pdv,
                        input logic [31:0] rob);
        s_dv = 1'b1; s_sel = sel; s_r1 = r1; s_r2 = r2;
        s_ps1 = p1; s_ps2 = p2; s_rd = d; s_pd = pdv; s_rob = rob;
    endtask

    task automatic apply();
        rst = s_rst; dispatch_valid = s_dv; rs_select = s_sel;
        dispatch_ps_ready1 = s_r1; dispatch_ps_ready2 = s_r2;
        ps1 = s_ps1; ps2 = s_ps2; rd = s_rd; pd = s_pd; rob_entry = s_rob;
        cdb_ps_id = s_cdb; add_fu_busy = s_abusy; multiply_fu_busy = s_mbusy;
    endtask

    // One clock: drive staged inputs, compare outputs with the model, advance the model.
    task automatic tick();
        int           ii [2];
        bit           ev [2];
        logic [159:0] ep [2];
        int           tb_bank, fi;
        bit           r1, r2;
        @(negedge clk);
        apply();
        #1;
        for (int b = 0; b < 2; b++) begin
            ii[b] = -1; ev[b] = 1'b0; ep[b] = '0;
            if (!((b == 0) ? s_abusy : s_mbusy)) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (ii[b] < 0 && mdl[b][k].v && mdl[b][k].r1 && mdl[b][k].r2) ii[b] = k;
                end
            end
            if (ii[b] >= 0) begin
                ev[b] = 1'b1;
                ep[b] = {mdl[b][ii[b]].rob, mdl[b][ii[b]].pd, mdl[b][ii[b]].rd,
                         mdl[b][ii[b]].ps2, mdl[b][ii[b]].ps1};
            end
        end
        check("add_regf_we", 160'(add_regf_we), 160'(ev[0]));
        check("add_cdb", add_cdb, ep[0]);
        check("multiply_fu_ready", 160'(multiply_fu_ready), 160'(ev[1]));
        check("multiply_cdb", multiply_cdb, ep[1]);

        if (s_rst) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < DEPTH; k++) begin
                    mdl[b][k].v = 1'b0; mdl[b][k].r1 = 1'b0; mdl[b][k].r2 = 1'b0;
                end
        end else begin
            tb_bank = (s_sel == 2'd0) ? 0 : (s_sel == 2'd1) ? 1 : -1;
            fi = -1;
            if (s_dv && tb_bank >= 0)
                for (int k = 0; k < DEPTH; k++)
                    if (fi < 0 && !mdl[tb_bank][k].v) fi = k;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < DEPTH; k++)
                    if (s_cdb != NONE && mdl[b][k].v) begin
                        if (mdl[b][k].ps1 == s_cdb) mdl[b][k].r1 = 1'b1;
                        if (mdl[b][k].ps2 == s_cdb) mdl[b][k].r2 = 1'b1;
                    end
            for (int b = 0; b < 2; b++)
                if (ii[b] >= 0) mdl[b][ii[b]].v = 1'b0;
            if (fi >= 0) begin
                r1 = s_r1; r2 = s_r2;
`ifdef RS_CDB_BYPASS_EN
                if (s_cdb != NONE && s_ps1 == s_cdb) r1 = 1'b1;
                if (s_cdb != NONE && s_ps2 == s_cdb) r2 = 1'b1;
`endif
                mdl[tb_bank][fi] = '{v: 1'b1, r1: r1, r2: r2, ps1: s_ps1, ps2: s_ps2,
                                     rd: s_rd, pd: s_pd, rob: s_rob};
            end
        end
    endtask

    initial begin
        int t34 [6];
        int wl  [7];
        int n;
        t34 = '{33, 37, 39, 35, 37, 41};
        wl  = '{33, 37, 39, 35, 41, -1, -1};
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < DEPTH; k++) mdl[b][k] = '{default: '0};
        idle();
        s_abusy = 1'b0; s_mbusy = 1'b0; s_rst = 1'b1;
        apply();
        repeat (2) @(posedge clk);
        tick();
        idle(); tick();

        // Operand woken by a later broadcast.
        disp(2'd0, 1'b1, 1'b0, 32'd32, 32'd33, 32'd2, 32'd45, 32'd0); s_cdb = 32'd38; tick();
        idle(); s_cdb = 32'd38; tick();
        check("r031_noissue", 160'(add_regf_we), 160'd0);
        idle(); s_cdb = 32'd33; tick();
        idle(); tick();
        check("r031_we", 160'(add_regf_we), 160'd1);
        check("r031_pkt", add_cdb, {32'd0, 32'd45, 32'd2, 32'd33, 32'd32});
        idle(); tick();

        // Ready at dispatch: issues the next cycle, for one cycle.
        disp(2'd0, 1'b1, 1'b1, 32'd34, 32'd35, 32'd4, 32'd65, 32'd1); tick();
        idle(); tick();
        check("r032_we", 160'(add_regf_we), 160'd1);
        check("r032_pkt", add_cdb, {32'd1, 32'd65, 32'd4, 32'd35, 32'd34});
        tick();
        check("r032_gone", 160'(add_regf_we), 160'd0);

        // FU busy holds the entry back.
        s_abusy = 1'b1;
        disp(2'd0, 1'b1, 1'b1, 32'd34, 32'd35, 32'd4, 32'd65, 32'd1); tick();
        idle(); tick();
        check("r033_busy1", 160'(add_regf_we), 160'd0);
        tick();
        check("r033_busy2", 160'(add_regf_we), 160'd0);
        s_abusy = 1'b0; tick();
        check("r033_release", 160'(add_regf_we), 160'd1);
        idle(); tick();

        // Bank overflow: only the first DEPTH dispatches stick.
        for (int i = 0; i < 6; i++) begin
            disp(2'd0, 1'b1, 1'b0, 32'd50, 32'(t34[i]), 32'(10 + i), 32'(100 + i), 32'(i));
            tick();
        end
        idle(); tick();
        check("r034_noissue", 160'(add_regf_we), 160'd0);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            idle(); s_cdb = (wl[i] < 0) ? NONE : 32'(wl[i]); tick();
            n += int'(add_regf_we);
        end
        check("r034_issued", 160'(n), 160'd4);

        // Multiply bank, then an ignored select code.
        disp(2'd1, 1'b1, 1'b1, 32'd60, 32'd61, 32'd7, 32'd70, 32'd5); tick();
        idle(); tick();
        check("r035_mul_we", 160'(multiply_fu_ready), 160'd1);
        check("r035_mul_pkt", multiply_cdb, {32'd5, 32'd70, 32'd7, 32'd61, 32'd60});
        check("r035_add_we", 160'(add_regf_we), 160'd0);
        disp(2'd2, 1'b1, 1'b1, 32'd62, 32'd63, 32'd8, 32'd71, 32'd6); tick();
        idle(); tick();
        check("r035_sel2_add", 160'(add_regf_we), 160'd0);
        check("r035_sel2_mul", 160'(multiply_fu_ready), 160'd0);

        // Reset flushes ready entries.
        s_abusy = 1'b1; s_mbusy = 1'b1;
        disp(2'd0, 1'b1, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5); tick();
        disp(2'd1, 1'b1, 1'b1, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10); tick();
        idle(); s_rst = 1'b1; tick();
        idle(); s_abusy = 1'b0; s_mbusy = 1'b0; tick();
        check("r036_add_we", 160'(add_regf_we), 160'd0);
        check("r036_add_cdb", add_cdb, 160'd0);
        check("r036_mul_we", 160'(multiply_fu_ready), 160'd0);
        check("r036_mul_cdb", multiply_cdb, 160'd0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            idle();
            s_rst   = ($urandom_range(0, 63) == 0);
            s_abusy = ($urandom_range(0, 3) == 0);
            s_mbusy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1)
                disp(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'd32 + $urandom_range(0, 7), 32'd32 + $urandom_range(0, 7),
                     $urandom, $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) s_cdb = 32'd32 + $urandom_range(0, 7);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
